// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared byte type and default FIFO depth for the UART receive path
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  localparam int UART_FIFO_DEPTH_DEF = 16;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through byte FIFO between uart_rx and the RAM loader
// Optional almost-full flag enabled by macro UART_RX_FIFO_AFULL_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH     = UART_FIFO_DEPTH_DEF,
  localparam int AW        = $clog2(DEPTH),
  parameter  int AFULL_THR = DEPTH - 2
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          fifo_clr_i,
  input  uart_byte_t    in_data_i,
  input  logic          in_data_vld_i,
  output logic          in_data_rdy_o,
  output uart_byte_t    out_data_o,
  output logic          out_data_vld_o,
  input  logic          out_data_rdy_i,
  output logic [AW:0]   fifo_level_o,
  output logic          fifo_afull_o
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_THR > DEPTH) begin : g_bad_cfg
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and AFULL_THR <= DEPTH");
  end

  uart_byte_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          push;
  logic          pop;

  // Flags come straight from the registered count, so rdy never depends on out_data_rdy_i.
  assign in_data_rdy_o  = (count != FULL_CNT);
  assign out_data_vld_o = (count != '0);
  assign fifo_level_o   = count;

  // A flush overrides both sides; the offered byte is dropped.
  assign push = in_data_vld_i & in_data_rdy_o & ~fifo_clr_i;
  assign pop  = out_data_vld_o & out_data_rdy_i & ~fifo_clr_i;

  // Empty array slots are never read out, keeping X out of out_data_o.
  assign out_data_o = out_data_vld_o ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= in_data_i;
    end
  end

  always_comb begin
    count_nxt = count;
    if (fifo_clr_i) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + (AW + 1)'(1);
        2'b01:   count_nxt = count - (AW + 1)'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fifo_clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
    end
  end

`ifdef UART_RX_FIFO_AFULL_EN
  logic afull_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (count_nxt >= (AW + 1)'(AFULL_THR));
    end
  end

  assign fifo_afull_o = afull_q;
`else
  assign fifo_afull_o = 1'b0;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int THR   = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  uart_byte_t in_data = '0;
  logic       in_vld = 1'b0;
  logic       in_rdy;
  uart_byte_t out_data;
  logic       out_vld;
  logic       out_rdy = 1'b0;
  logic [4:0] level;
  logic       afull;

  int         errors = 0;
  int         checks = 0;
  uart_byte_t sb[$];
  int         mcount = 0;
  logic       exp_afull = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .fifo_clr_i     (clr),
    .in_data_i      (in_data),
    .in_data_vld_i  (in_vld),
    .in_data_rdy_o  (in_rdy),
    .out_data_o     (out_data),
    .out_data_vld_o (out_vld),
    .out_data_rdy_i (out_rdy),
    .fifo_level_o   (level),
    .fifo_afull_o   (afull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check against the model, then advance to the next falling edge.
  task automatic step(input bit vld, input uart_byte_t d, input bit rdy, input bit c);
    bit accepted;
    bit popped;
    in_vld  = vld;
    in_data = d;
    out_rdy = rdy;
    clr     = c;
    #1;
    chk("in_rdy", 32'(in_rdy), 32'(mcount != DEPTH));
    chk("out_vld", 32'(out_vld), 32'(mcount != 0));
    chk("level", 32'(level), 32'(mcount));
    chk("afull", 32'(afull), 32'(exp_afull));
    if (mcount != 0) chk("out_head", 32'(out_data), 32'(sb[0]));
    else             chk("out_idle", 32'(out_data), 32'h0);
    if (c) begin
      sb.delete();
      mcount = 0;
    end else begin
      accepted = vld && (mcount != DEPTH);
      popped   = rdy && (mcount != 0);
      if (popped) void'(sb.pop_front());
      if (accepted) sb.push_back(d);
      mcount = mcount + int'(accepted) - int'(popped);
    end
`ifdef UART_RX_FIFO_AFULL_EN
    exp_afull = (mcount >= THR);
`else
    exp_afull = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_in_rdy", 32'(in_rdy), 32'h1);
    chk("rst_out_vld", 32'(out_vld), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);

    // Two bytes, held, then drained back to back
    step(1, 8'hA5, 0, 0);
    step(1, 8'h3C, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Fill to full, hold the 17th byte, free one slot, then drain
    for (int i = 0; i < DEPTH; i++) step(1, uart_byte_t'(i), 0, 0);
    step(1, 8'h10, 0, 0);
    step(1, 8'h10, 1, 0);
    step(1, 8'h10, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Steady push+pop at level 5 across pointer wrap
    for (int i = 0; i < 5; i++) step(1, uart_byte_t'(8'h20 + i), 0, 0);
    for (int i = 0; i < 40; i++) step(1, uart_byte_t'(8'h40 + i), 1, 0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Flush at level 7 alongside a push of FF
    for (int i = 0; i < 7; i++) step(1, uart_byte_t'(8'h80 + i), 0, 0);
    step(1, 8'hFF, 0, 1);
    step(0, 8'h00, 0, 0);
    step(1, 8'h5A, 0, 0);
    step(1, 8'h6B, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Almost-full threshold crossing in both directions
    for (int i = 0; i < THR; i++) step(1, uart_byte_t'(8'hC0 + i), 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < THR - 1; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 3; i++) step(1, uart_byte_t'(8'hE0 + i), 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'h0);
    chk("arst_out_vld", 32'(out_vld), 32'h0);
    chk("arst_in_rdy", 32'(in_rdy), 32'h1);
    chk("arst_out_data", 32'(out_data), 32'h0);
    sb.delete();
    mcount    = 0;
    exp_afull = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 1, 0);
    step(1, 8'h77, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_rx_fifo
